// File: rtl/aes_block_packer.sv
// Packs a plaintext byte stream into 128-bit blocks, pads a short final block,
// and holds each block on blk_data while the UART transmits it.
module aes_block_packer #(
    parameter int          PAD_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [127:0]     blk_data,
    output logic             en_tx,
    input  logic             u_tx_done,
    output logic             busy,
    output logic             tx_err,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [3:0]       byte_idx
);

    typedef enum logic [1:0] {FILL, PAD, SEND} state_t;

    state_t      state;
    logic [31:0] tmo_cnt;
    logic [7:0]  pad_byte;
    logic        done_ok;
    logic        tmo_hit;

    always_comb begin
        pad_byte = 8'h00;
        if (PAD_MODE == 1) begin
            pad_byte = 8'd16 - {4'd0, byte_idx};
        end
    end

    // tmo_cnt is zero only in the first SEND cycle, which masks a stale done
    assign done_ok = u_tx_done && (tmo_cnt != 32'd0);
    assign tmo_hit = (TIMEOUT_CYC != 0) && ((tmo_cnt + 32'd1) == TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FILL;
            blk_data <= '0;
            byte_idx <= '0;
            en_tx    <= 1'b0;
            tx_err   <= 1'b0;
            blk_cnt  <= '0;
            tmo_cnt  <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (s_valid && s_ready) begin
                        // Byte k lands at [8*(15-k) +: 8]; 15-k is simply ~k in 4 bits
                        blk_data[{~byte_idx, 3'b000} +: 8] <= s_data;
                        if (byte_idx == 4'd15) begin
                            byte_idx <= '0;
                            state    <= SEND;
                            s_ready  <= 1'b0;
                            busy     <= 1'b1;
                            en_tx    <= 1'b1;
                            tmo_cnt  <= '0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            if (s_last) begin
                                state   <= PAD;
                                s_ready <= 1'b0;
                                busy    <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    for (int k = 0; k < 16; k++) begin
                        if (4'(k) >= byte_idx) begin
                            blk_data[8*(15-k) +: 8] <= pad_byte;
                        end
                    end
                    byte_idx <= '0;
                    state    <= SEND;
                    en_tx    <= 1'b1;
                    tmo_cnt  <= '0;
                end
                SEND: begin
                    if (done_ok) begin
                        blk_cnt  <= blk_cnt + CNT_W'(1);
                        blk_data <= '0;
                        en_tx    <= 1'b0;
                        busy     <= 1'b0;
                        s_ready  <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= FILL;
                    end else if (tmo_hit) begin
                        tx_err   <= 1'b1;
                        blk_data <= '0;
                        en_tx    <= 1'b0;
                        busy     <= 1'b0;
                        s_ready  <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    en_tx   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: two instances (zero and count padding)
// share one stimulus stream; expected blocks are queued as bytes are driven.
module tb_aes_block_packer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             u_tx_done;

    logic             s_ready0, en_tx0, busy0, tx_err0;
    logic [127:0]     blk_data0;
    logic [CNT_W-1:0] blk_cnt0;
    logic [3:0]       byte_idx0;

    logic             s_ready1, en_tx1, busy1, tx_err1;
    logic [127:0]     blk_data1;
    logic [CNT_W-1:0] blk_cnt1;
    logic [3:0]       byte_idx1;

    aes_block_packer #(.PAD_MODE(0), .TIMEOUT_CYC(50), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready0), .blk_data(blk_data0), .en_tx(en_tx0), .u_tx_done(u_tx_done),
        .busy(busy0), .tx_err(tx_err0), .blk_cnt(blk_cnt0), .byte_idx(byte_idx0)
    );

    aes_block_packer #(.PAD_MODE(1), .TIMEOUT_CYC(50), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready1), .blk_data(blk_data1), .en_tx(en_tx1), .u_tx_done(u_tx_done),
        .busy(busy1), .tx_err(tx_err1), .blk_cnt(blk_cnt1), .byte_idx(byte_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp0_q[$];
    logic [127:0] exp1_q[$];
    logic [7:0]   stim[16];

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blockModel(input int n, input int pad_mode);
        logic [127:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < n) b[8*(15-k) +: 8] = stim[k];
            else if (pad_mode == 1) b[8*(15-k) +: 8] = 8'(16 - n);
            else b[8*(15-k) +: 8] = 8'h00;
        end
        return b;
    endfunction

    // Drives stim[0..n-1] back to back; returns at the negedge after the last acceptance
    task automatic applyStimulus(input int n, input bit with_last);
        if (n == 16 || with_last) begin
            exp0_q.push_back(blockModel(n, 0));
            exp1_q.push_back(blockModel(n, 1));
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = stim[i];
            s_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitTx(input string tag);
        int w;
        w = 0;
        while (!en_tx0 && w < 8) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_entx_seen"}, en_tx0, 1'b1);
        if (en_tx0 && exp0_q.size() > 0 && exp1_q.size() > 0) begin
            checkOutput({tag, "_blk0"}, blk_data0, exp0_q.pop_front());
            checkOutput({tag, "_blk1"}, blk_data1, exp1_q.pop_front());
        end
    endtask

    task automatic completeTx(input string tag, input int delay, input logic [CNT_W-1:0] exp_cnt);
        int high;
        high = 0;
        repeat (delay) begin
            if (en_tx0) high++;
            @(negedge clk);
        end
        u_tx_done = 1'b1;
        @(negedge clk);
        u_tx_done = 1'b0;
        checkOutput({tag, "_en_high_cycles"}, high, delay);
        checkOutput({tag, "_en_low"}, en_tx0, 1'b0);
        checkOutput({tag, "_cnt"}, blk_cnt0, exp_cnt);
        checkOutput({tag, "_ready"}, s_ready0, 1'b1);
        checkOutput({tag, "_blk_clear"}, blk_data0, 128'h0);
    endtask

    task automatic seqStim(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 16; i++) stim[i] = base + 8'(i) * step;
    endtask

    initial begin
        int high;
        reset = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; u_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", s_ready0, 1'b1);
        checkOutput("rst_en", en_tx0, 1'b0);
        checkOutput("rst_busy", busy0, 1'b0);
        checkOutput("rst_err", tx_err0, 1'b0);
        checkOutput("rst_cnt", blk_cnt0, 0);
        checkOutput("rst_idx", byte_idx0, 0);
        checkOutput("rst_blk", blk_data0, 128'h0);
        reset = 1'b1;

        // Full block 00..0F
        seqStim(8'h00, 8'h01);
        applyStimulus(16, 1'b0);
        checkOutput("full_latency", en_tx0, 1'b1);
        checkOutput("full_ready_low", s_ready0, 1'b0);
        waitTx("full");
        checkOutput("full_blk_const", blk_data0, 128'h000102030405060708090A0B0C0D0E0F);
        completeTx("full", 20, 16'd1);

        // Short block AA BB CC with s_last
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
        applyStimulus(3, 1'b1);
        checkOutput("short_pad_en", en_tx0, 1'b0);
        checkOutput("short_pad_busy", busy0, 1'b1);
        checkOutput("short_pad_ready", s_ready0, 1'b0);
        @(negedge clk);
        checkOutput("short_latency", en_tx0, 1'b1);
        waitTx("short");
        checkOutput("short_zero_const", blk_data0, {24'hAABBCC, 104'h0});
        completeTx("short", 3, 16'd2);

        // 13 bytes of 11 with s_last
        for (int i = 0; i < 16; i++) stim[i] = 8'h11;
        applyStimulus(13, 1'b1);
        waitTx("cpad");
        checkOutput("cpad_tail", blk_data1[23:0], 24'h030303);
        completeTx("cpad", 5, 16'd3);

        // Done held high before the block; s_valid pushed during SEND
        seqStim(8'h40, 8'h03);
        u_tx_done = 1'b1;
        applyStimulus(16, 1'b0);
        waitTx("stale");
        s_valid = 1'b1; s_data = 8'hEE;
        @(negedge clk);
        checkOutput("stale_first_ignored", en_tx0, 1'b1);
        checkOutput("bp_ready_low", s_ready0, 1'b0);
        checkOutput("bp_idx_send", byte_idx0, 0);
        @(negedge clk);
        s_valid = 1'b0; u_tx_done = 1'b0;
        checkOutput("stale_done_second", en_tx0, 1'b0);
        checkOutput("stale_cnt", blk_cnt0, 16'd4);
        checkOutput("bp_idx_after", byte_idx0, 0);
        @(negedge clk);
        checkOutput("bp_idx_idle", byte_idx0, 0);

        // Timeout: never assert done
        seqStim(8'h90, 8'h05);
        applyStimulus(16, 1'b0);
        waitTx("tmo");
        high = 0;
        while (en_tx0 && high < 200) begin
            high++;
            @(negedge clk);
        end
        checkOutput("tmo_cycles", high, 50);
        checkOutput("tmo_err", tx_err0, 1'b1);
        checkOutput("tmo_cnt", blk_cnt0, 16'd4);
        checkOutput("tmo_ready", s_ready0, 1'b1);
        seqStim(8'hF0, 8'h01);
        applyStimulus(16, 1'b0);
        waitTx("post_tmo");
        completeTx("post_tmo", 10, 16'd5);
        checkOutput("tmo_err_sticky", tx_err0, 1'b1);

        // Reset after 7 bytes
        seqStim(8'h20, 8'h01);
        applyStimulus(7, 1'b0);
        checkOutput("mid_idx7", byte_idx0, 7);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("mid_rst_idx", byte_idx0, 0);
        checkOutput("mid_rst_blk", blk_data0, 128'h0);
        checkOutput("mid_rst_err", tx_err0, 1'b0);
        checkOutput("mid_rst_cnt", blk_cnt0, 0);
        checkOutput("mid_rst_ready", s_ready0, 1'b1);
        seqStim(8'h60, 8'h02);
        applyStimulus(16, 1'b0);
        waitTx("after_mid");
        completeTx("after_mid", 4, 16'd1);

        // Reset during SEND
        seqStim(8'hC0, 8'h07);
        applyStimulus(16, 1'b0);
        waitTx("send_rst");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("send_rst_en", en_tx0, 1'b0);
        checkOutput("send_rst_busy", busy0, 1'b0);
        checkOutput("send_rst_cnt", blk_cnt0, 0);
        checkOutput("send_rst_blk", blk_data0, 128'h0);
        checkOutput("send_rst_ready", s_ready0, 1'b1);
        seqStim(8'h01, 8'h11);
        applyStimulus(16, 1'b0);
        waitTx("after_send_rst");
        completeTx("after_send_rst", 2, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
- Upstream feeder for the AES-over-UART top level.
- Accepts a plaintext byte stream on a valid/ready interface and packs 16 bytes into one 128-bit block, padding a short final block on s_last.
- Presents the block on blk_data and drives en_tx until the UART signals completion on u_tx_done.
- Provides a transmit timeout, sticky error flag and sent-block counter.

Parameters:
- PAD_MODE, 0: padding selection. 0 = zero fill. 1 = count fill, where each pad byte = 16 − valid byte count.
- TIMEOUT_CYC, 1000000: maximum SEND cycles to wait for u_tx_done before abort. 0 disables the timeout.
- CNT_W, 16: width of blk_cnt.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- s_data  in  8  plaintext byte
- s_valid  in  1  s_data valid
- s_last  in  1  qualifies the current byte as the final byte of the message
- s_ready  out  1  packer can accept a byte this cycle
- blk_data  out  128  packed block, goes to the AES/UART data_in
- en_tx  out  1  transmit enable to the UART, goes to en_tx
- u_tx_done  in  1  UART transmit-complete indication
- busy  out  1  high in PAD or SEND
- tx_err  out  1  sticky timeout flag
- blk_cnt  out  CNT_W  number of blocks completed successfully, wraps
- byte_idx  out  4  bytes held in the current partial block

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=FILL; blk_data=0, byte_idx=0, en_tx=0, tx_err=0, blk_cnt=0, timeout counter=0.
  - s_ready=1 in the first cycle after reset.
  - Reset in any state aborts immediately; any partial block is discarded.
- Byte order: byte k of a block (k=0 first received) occupies blk_data[127-8k -: 8]. The first byte lands in [127:120].
- State FILL:
  - s_ready=1, busy=0.
  - On s_valid & s_ready: write the byte at byte_idx, then byte_idx++.
  - If the accepted byte is number 16 (byte_idx was 15): byte_idx←0, go to SEND next cycle.
  - Else if s_last=1 on the accepted byte: go to PAD, with count = new byte_idx (1..15).
  - s_last with a full block goes straight to SEND; no extra pad block is generated.
  - s_last=1 with s_valid=0 is ignored.
- State PAD (exactly 1 cycle):
  - s_ready=0.
  - Bytes count..15 are written with 8'h00 (PAD_MODE=0) or with 16−count (PAD_MODE=1).
  - byte_idx←0, go to SEND.
- State SEND:
  - s_ready=0, en_tx=1, busy=1; blk_data held stable throughout.
  - u_tx_done is ignored in the first SEND cycle, so a stale done from a previous block is not taken as completion.
  - From the second SEND cycle, u_tx_done=1 completes the block: en_tx←0, blk_cnt++ (wraps at 2^CNT_W), clear blk_data, go to FILL. Earliest new byte acceptance is the next cycle.
  - Timeout counter increments each SEND cycle. When it reaches TIMEOUT_CYC (nonzero) before done: tx_err←1 (sticky until reset), en_tx←0, block dropped, blk_cnt unchanged, go to FILL.
  - If done and timeout land in the same cycle, done wins.
- Latency:
  - 16th byte accepted at cycle N → en_tx=1 at N+1.
  - Short final block: s_last at N → PAD at N+1 → en_tx=1 at N+2.
- Throughput: at most one byte per cycle. s_ready is never high while en_tx=1.
- All outputs are registered.

Test Plan:
- Full block: stream bytes 8'h00..8'h0F back-to-back, pulse u_tx_done 20 cycles after en_tx rises → blk_data=128'h000102030405060708090A0B0C0D0E0F, en_tx high exactly from N+1 until the done cycle, blk_cnt=1, s_ready returns 1.
- Short block, zero padding: PAD_MODE=0, bytes 8'hAA,8'hBB,8'hCC with s_last on 8'hCC → blk_data=128'hAABBCC followed by 26 zero nibbles; en_tx at s_last cycle +2.
- Short block, count padding: PAD_MODE=1, 13 bytes of 8'h11 with s_last → final three bytes = 8'h03,8'h03,8'h03.
- Stale done and backpressure:
  - Hold u_tx_done=1 continuously → block completes on the second SEND cycle, not the first.
  - s_valid asserted during SEND → no byte accepted, byte_idx stays 0.
- Timeout: TIMEOUT_CYC=50, never assert u_tx_done → en_tx drops after 50 SEND cycles, tx_err=1 and stays 1 across the next successful block, blk_cnt unchanged by the timed-out block.
- Reset mid-operation: assert reset=0 after 7 bytes, and separately in SEND → all outputs return to reset values the next cycle; subsequent 16-byte stream packs from byte 0.
